// File: rtl/bfs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfs_pkg
// Description : Shared types and constants for the BFS update packer.
// Revision    : 1.0 - initial release
// ============================================================================
package bfs_pkg;

  localparam int LINE_W         = 512;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 16;

  localparam logic [1:0] CTRL_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/bfs_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bfs_line_fifo
// Description : Depth 2^AW first-word-fall-through line FIFO with full/empty
//               flags and a synchronous clear. Head reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module bfs_line_fifo #(
  parameter int AW = 2,
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer update with clear taking priority over traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bfs_update_packer.sv
`default_nettype none
// ============================================================================
// Module      : bfs_update_packer
// Description : Packs 32-bit BFS vertex updates sixteen to a 512-bit line,
//               buffers lines in a FIFO, pads/flushes a partial line at end
//               of input and signals done once drained.
//               Optional statistics counters: define BFS_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bfs_update_packer
  import bfs_pkg::*;
#(
  parameter int          FIFO_AW  = 2,
  parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] update_in,
  input  logic              update_valid,
  input  logic              last_input_in,
  input  logic [1:0]        control_in,
  output logic [LINE_W-1:0] line_out,
  output logic              line_valid,
  input  logic              line_ready,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       lines_emitted,
  output logic [31:0]       lines_padded
);

  packer_state_t     state;
  packer_state_t     state_nx;
  logic [3:0]        slot_cnt;
  logic [LINE_W-1:0] asm_line;
  logic [LINE_W-1:0] line_data;
  logic [4:0]        fill_cnt;
  logic              clear;
  logic              accepting;
  logic              take;
  logic              flush;
  logic              full_push;
  logic              pad_push;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign clear     = (control_in == CTRL_CLEAR);
  assign accepting = (state == IDLE) || (state == FILL);
  assign take      = accepting && update_valid && !clear;
  assign flush     = accepting && last_input_in && !clear;
  // Number of slots occupied once this cycle's word (if any) is packed.
  assign fill_cnt  = {1'b0, slot_cnt} + {4'd0, take};
  assign full_push = take && (slot_cnt == 4'd15);
  // A flush only produces a padded line when a partial line remains.
  assign pad_push  = flush && (fill_cnt != 5'd0) && (fill_cnt != 5'd16);
  assign push      = full_push || pad_push;
  assign pop       = line_valid && line_ready;
  assign line_valid = !fifo_empty;
  assign done      = (state == DONE);

  // Outgoing line: assembly register, incoming word merged, tail padded on flush.
  always_comb begin
    line_data = asm_line;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (take && (slot_cnt == 4'(i))) begin
        line_data[i*WORD_W +: WORD_W] = update_in;
      end else if (pad_push && (5'(i) >= fill_cnt)) begin
        line_data[i*WORD_W +: WORD_W] = PAD_WORD;
      end
    end
  end

  // Next-state logic; clear returns to IDLE from anywhere.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (flush) state_nx = DRAIN; else if (take) state_nx = FILL;
      FILL:    if (flush) state_nx = DRAIN;
      DRAIN:   if (fifo_empty) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Slot counter and assembly register; a flush starts the next line fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      asm_line <= '0;
    end else if (clear) begin
      slot_cnt <= '0;
      asm_line <= '0;
    end else begin
      if (take) asm_line[{slot_cnt, 5'd0} +: WORD_W] <= update_in;
      if (flush)     slot_cnt <= '0;
      else if (take) slot_cnt <= slot_cnt + 4'd1;
    end
  end

  // Sticky overflow: a line was dropped because no slot was free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   overflow <= 1'b0;
    else if (clear)                             overflow <= 1'b0;
    else if (push && fifo_full && !pop)         overflow <= 1'b1;
  end

  bfs_line_fifo #(
    .AW (FIFO_AW),
    .DW (LINE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (line_data),
    .pop       (pop),
    .head      (line_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef BFS_PACKER_STATS_EN
  // Wrapping counters of popped lines and accepted padded lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lines_emitted <= '0;
      lines_padded  <= '0;
    end else if (clear) begin
      lines_emitted <= '0;
      lines_padded  <= '0;
    end else begin
      if (pop) lines_emitted <= lines_emitted + 32'd1;
      if (pad_push && (!fifo_full || pop)) lines_padded <= lines_padded + 32'd1;
    end
  end
`else
  assign lines_emitted = '0;
  assign lines_padded  = '0;
`endif

endmodule
`default_nettype wire
